mux2_rr_arbiter: RTL
====================

// Module: mux2_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 2:1 multiplexer datapath between two requesters.
//  Issues registered grants, drives the mux select, and registers the selected data with a valid flag.
//  Sits in front of any single-consumer resource fed by two producers.
//  Bounds grant tenure so neither requester starves the other.
// PARAMETERS
//  DATA_W    8   width of each data input and of out_data
//  MAX_HOLD  4   max consecutive granted cycles while the other side requests (>=1)
// PORTS
//  clk       in   1        single clock; all state changes on rising edge
//  rst_n     in   1        asynchronous, active-low reset
//  req0      in   1        requester 0 wants the datapath; level, held until done
//  req1      in   1        requester 1 wants the datapath; level
//  data0     in   DATA_W   requester 0 payload, sampled while gnt0=1
//  data1     in   DATA_W   requester 1 payload, sampled while gnt1=1
//  gnt0      out  1        registered grant to requester 0
//  gnt1      out  1        registered grant to requester 1
//  sel       out  1        mux select: 0=data0, 1=data1; equals gnt1
//  out_valid out  1        out_data holds a granted sample
//  out_data  out  DATA_W   registered mux output
//  busy      out  1        a grant is active (gnt0|gnt1)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, last=1, hold_cnt=0.
//  Reset values: gnt0=gnt1=sel=busy=out_valid=0; out_data=0. Applies immediately, mid-operation included.
//  FSM states: IDLE, G0, G1. Outputs decoded from state only (Moore): gnt0=(G0), gnt1=(G1).
//  IDLE:
//   - req0&req1 -> grant to ~last, so req0 wins the first contention after reset.
//   - req0 only -> G0; req1 only -> G1; none -> stay IDLE.
//  Gx (other side = y):
//   - !reqx & reqy -> Gy.
//   - !reqx & !reqy -> IDLE.
//   - reqx & reqy & hold_cnt==MAX_HOLD-1 -> Gy (forced switch).
//   - otherwise stay Gx.
//  last <= x on every exit from Gx.
//  hold_cnt: cleared on entry to any grant state; +1 per cycle in Gx; saturates at MAX_HOLD-1.
//   - A lone requester keeps the grant indefinitely.
//   - Switch Gx->Gy directly, no IDLE bubble; hold_cnt restarts at 0.
//  Latency: req edge at cycle N -> gnt at N+1 (from IDLE).
//  out_data <= sel ? data1 : data0 every cycle that busy=1; otherwise hold.
//  out_valid <= busy, so out_valid/out_data lag gnt by exactly one cycle.
//  Deassertion of req in cycle N: gnt drops at N+1, out_valid drops at N+2.
//  Requests arriving during reset are ignored; first evaluation on the first edge after rst_n rises.
//  No combinational path from req/data to any output.
// STRUCTURE
//  Shared package: state encoding constants ST_IDLE=2'd0, ST_G0=2'd1, ST_G1=2'd2.
//  Shared package also holds the hold-counter width function clog2(MAX_HOLD).
//  Datapath sub-module: the team's existing 2:1 multiplexer cell, instantiated per bit
//  (generate over DATA_W) with select=sel, feeding the out_data register.
//  Control (FSM, last, hold_cnt) stays in this module.
// TESTING
//  1 Reset then req0=1 at cycle 2 (data0=8'hA5)
//    -> gnt0=1 cycle 3; out_valid=1, out_data=A5 cycle 4.
//  2 req0=req1=1 same cycle from IDLE after reset
//    -> G0 for 4 cycles, then G1 for 4, then G0 (MAX_HOLD=4); never both grants high.
//  3 req1 alone held 10 cycles
//    -> gnt1 stays 1 all 10+1 cycles; sel=1; no forced switch.
//  4 In G0, drop req0 while req1=1 (data1=8'h3C)
//    -> next cycle gnt1=1, gnt0=0, no IDLE cycle; out_data=3C one cycle later.
//  5 rst_n=0 asynchronously mid-G1
//    -> gnt1, busy, out_valid, out_data go 0 before next clk edge.
//    -> after release with both requesting, req0 granted first.
//  6 Both reqs drop in G0
//    -> IDLE next cycle, busy=0; out_valid=0 one cycle later; out_data holds last value.

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// state encoding and the hold-counter width helper.
package mux2_rr_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_G0   = 2'd1;
   localparam logic [1:0] ST_G1   = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      G0   = ST_G0,
      G1   = ST_G1
   } arb_state_t;

   // Bits needed to count 0..value-1; returns 0 for value<=1.
   function automatic int clog2(input int value);
      int width;
      int rem;
      width = 0;
      rem   = value - 1;
      while (rem > 0) begin
         width = width + 1;
         rem   = rem >> 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Request/grant/data bundle between the two producers and the arbiter.
// master = producer side, slave = arbiter side.
interface mux2_rr_arbiter_if #(parameter int DATA_W = 8);

   logic              req0;
   logic              req1;
   logic [DATA_W-1:0] data0;
   logic [DATA_W-1:0] data1;
   logic              gnt0;
   logic              gnt1;
   logic              sel;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              busy;

   modport master (
      output req0, req1, data0, data1,
      input  gnt0, gnt1, sel, out_valid, out_data, busy
   );

   modport slave (
      input  req0, req1, data0, data1,
      output gnt0, gnt1, sel, out_valid, out_data, busy
   );

endinterface

// File: rtl/mux2_rr_arbiter_mux.sv
// Single-bit 2:1 multiplexer cell: y = s ? b : a.
module mux2_rr_arbiter_mux (
   input  logic a,
   input  logic b,
   input  logic s,
   output logic y
);

   assign y = s ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between two requesters, with bounded
// grant tenure under contention and a registered, valid-flagged output sample.
module mux2_rr_arbiter
   import mux2_rr_arbiter_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input logic              clk,
   input logic              rst_n,
   mux2_rr_arbiter_if.slave bus
);

   localparam int HOLD_W = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_t        state;
   arb_state_t        next_state;
   logic              last;
   logic [HOLD_W-1:0] hold_cnt;
   logic              gnt0_q;
   logic              gnt1_q;
   logic              busy;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] mux_y;

   // last=1 means requester 1 was served most recently, so requester 0 wins a tie.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (bus.req0 && bus.req1) next_state = last ? G0 : G1;
            else if (bus.req0)        next_state = G0;
            else if (bus.req1)        next_state = G1;
         end
         G0: begin
            if (!bus.req0)                                next_state = bus.req1 ? G1 : IDLE;
            else if (bus.req1 && (hold_cnt == HOLD_LAST)) next_state = G1;
         end
         G1: begin
            if (!bus.req1)                                next_state = bus.req0 ? G0 : IDLE;
            else if (bus.req0 && (hold_cnt == HOLD_LAST)) next_state = G0;
         end
         default: next_state = IDLE;
      endcase
   end

   // Grants are registered copies of the next state, so they never depend combinationally on req.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= 1'b1;
         hold_cnt <= '0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
      end else begin
         state  <= next_state;
         gnt0_q <= (next_state == G0);
         gnt1_q <= (next_state == G1);
         if ((state != IDLE) && (next_state != state)) begin
            last <= (state == G1);
         end
         if (next_state != state) begin
            hold_cnt <= '0;
         end else if ((state != IDLE) && (hold_cnt != HOLD_LAST)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end
   end

   assign busy = gnt0_q | gnt1_q;

   for (genvar i = 0; i < DATA_W; i++) begin : g_mux
      mux2_rr_arbiter_mux u_mux (
         .a (bus.data0[i]),
         .b (bus.data1[i]),
         .s (gnt1_q),
         .y (mux_y[i])
      );
   end

   // out_data keeps the last granted sample while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= busy;
         if (busy) begin
            data_q <= mux_y;
         end
      end
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.sel       = gnt1_q;
   assign bus.busy      = busy;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;

endmodule
